// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV M-extension unit (radix-2 shift-add multiply, restoring divide), one op in flight.
// Define MDU_WORD_OP_EN to build the RV64 *W datapath (in_op[3]); only meaningful with XLEN=64.
module mdu_iter #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, BUSY, FIN, DONE} state_e;
  localparam logic [XLEN-1:0] ONES = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
  logic [2:0]        f3_q, f3_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;
`ifdef MDU_WORD_OP_EN
  logic              word_q, word_d;
`else
  logic              unused_op3;
  assign unused_op3 = in_op[3];
`endif

  // Request decode: width-normalised operands, operand signs, magnitudes, fast-path detection
  logic              word_in, in_sa, in_sb, fast;
  logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b, most_neg, fast_res;
  logic [CNT_W-1:0]  n_iter;

  always_comb begin
    word_in  = 1'b0;
    a_ext    = in_a;
    b_ext    = in_b;
    most_neg = {1'b1, {(XLEN-1){1'b0}}};
    n_iter   = CNT_W'(XLEN);
`ifdef MDU_WORD_OP_EN
    if (in_op[3]) begin
      word_in  = 1'b1;
      a_ext    = {{(XLEN-32){in_a[31]}}, in_a[31:0]};
      b_ext    = {{(XLEN-32){in_b[31]}}, in_b[31:0]};
      most_neg = {{(XLEN-31){1'b1}}, 31'b0};
      n_iter   = CNT_W'(32);
    end
`endif
    if (in_op[2]) begin
      in_sa = ~in_op[0] & a_ext[XLEN-1];
      in_sb = ~in_op[0] & b_ext[XLEN-1];
    end else begin
      // MUL low half is sign-agnostic, so only MULH/MULHSU carry operand signs
      in_sa = ~word_in & ((in_op[1:0] == 2'b01) | (in_op[1:0] == 2'b10)) & a_ext[XLEN-1];
      in_sb = ~word_in & (in_op[1:0] == 2'b01) & b_ext[XLEN-1];
    end
    mag_a = in_sa ? -a_ext : a_ext;
    mag_b = in_sb ? -b_ext : b_ext;
`ifdef MDU_WORD_OP_EN
    if (word_in) begin
      mag_a = {{(XLEN-32){1'b0}}, mag_a[31:0]};
      mag_b = {{(XLEN-32){1'b0}}, mag_b[31:0]};
    end
`endif
    fast = in_op[2] & ((b_ext == '0) | (~in_op[0] & (a_ext == most_neg) & (b_ext == ONES)));
    if (b_ext == '0) fast_res = in_op[1] ? a_ext : ONES;
    else             fast_res = in_op[1] ? '0 : a_ext;
  end

  // Iteration step and final sign correction/selection
  logic [XLEN:0]     mul_sum, div_sh, div_trial;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fin_res;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    div_sh    = {hi_q, lo_q[XLEN-1]};
    // div_sh < 2*divisor, so bit XLEN of the difference is a clean borrow flag
    div_trial = div_sh - {1'b0, dvs_q};
    prod      = {hi_q, lo_q};
    if (sa_q ^ sb_q) prod = -prod;
    quo = (sa_q ^ sb_q) ? -lo_q : lo_q;
    rem = sa_q ? -hi_q : hi_q;
    case (f3_q)
      3'b000:                 fin_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = quo;
      default:                fin_res = rem;
    endcase
`ifdef MDU_WORD_OP_EN
    // 32 iterations leave the word product at prod[95:32]
    if (word_q) fin_res = f3_q[2] ? {{(XLEN-32){fin_res[31]}}, fin_res[31:0]}
                                  : {{(XLEN-32){prod[63]}}, prod[63:32]};
`endif
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    dvs_d        = dvs_q;
    f3_d         = f3_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
`ifdef MDU_WORD_OP_EN
    word_d       = word_q;
`endif
    case (state_q)
      IDLE: if (in_valid && !flush) begin
        f3_d = in_op[2:0];
        sa_d = in_sa;
        sb_d = in_sb;
        hi_d = '0;
`ifdef MDU_WORD_OP_EN
        word_d = word_in;
`endif
        if (in_op[2]) begin
          lo_d  = mag_a;
          dvs_d = mag_b;
`ifdef MDU_WORD_OP_EN
          if (word_in) lo_d = mag_a << 32;
`endif
        end else begin
          lo_d  = mag_b;
          dvs_d = mag_a;
        end
        if (fast) begin
          state_d      = DONE;
          out_result_d = fast_res;
        end else begin
          state_d = BUSY;
          cnt_d   = n_iter;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (f3_q[2]) begin
          if (!div_trial[XLEN]) begin
            hi_d = div_trial[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(1)) state_d = FIN;
      end
      FIN: begin
        out_result_d = fin_res;
        state_d      = DONE;
      end
      DONE: begin
        // out_valid trails entry into DONE by one edge
        if (!out_valid_q) out_valid_d = 1'b1;
        else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      dvs_q        <= '0;
      f3_q         <= '0;
      sa_q         <= 1'b0;
      sb_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
`ifdef MDU_WORD_OP_EN
      word_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      dvs_q        <= dvs_d;
      f3_q         <= f3_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
`ifdef MDU_WORD_OP_EN
      word_q       <= word_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed + random bench for mdu_iter (XLEN=64) against a plain-arithmetic reference model.
module tb_mdu_iter;
  logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]  in_op = '0;
  logic [63:0] in_a = '0, in_b = '0;
  logic        in_ready, out_valid, busy;
  logic [63:0] out_result;
  int          total = 0, bad = 0;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] M1  = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy)
  );

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0]  as, bs;
    logic signed [127:0] sa128, sb128, ua128, ub128;
    logic [127:0]        p;
    as = a; bs = b;
    sa128 = as; sb128 = bs;
    ua128 = {64'b0, a}; ub128 = {64'b0, b};
    p = '0;
    case (op[2:0])
      3'd0: begin p = sa128 * sb128; return p[63:0]; end
      3'd1: begin p = sa128 * sb128; return p[127:64]; end
      3'd2: begin p = sa128 * ub128; return p[127:64]; end
      3'd3: begin p = ua128 * ub128; return p[127:64]; end
      3'd4: begin
        if (b == 0) return M1;
        if (a == MIN && b == M1) return a;
        return as / bs;
      end
      3'd5: return (b == 0) ? M1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == M1) return 64'd0;
        return as % bs;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_exp(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == MIN && b == M1))) return 1;
    return 66;
  endfunction

  // Issue one op, measure edges from accept to out_valid, optionally stall, then hand off.
  task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_lat, input int hold, input string tag);
    int lat;
    @(negedge clk);
    chk(64'(in_ready), 64'd1, {tag, "/rdy"});
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = ~op; in_a = ~a; in_b = ~b;
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk(64'(lat), 64'(exp_lat), {tag, "/lat"});
    chk(out_result, exp, {tag, "/res"});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk(64'({out_valid, in_ready, busy}), 64'b101, {tag, "/stall"});
      chk(out_result, exp, {tag, "/stable"});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk(64'({out_valid, in_ready, busy}), 64'b010, {tag, "/hs"});
    chk(out_result, exp, {tag, "/held"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk(64'({out_valid, busy, in_ready}), 64'b001, "reset/ctl");
    chk(out_result, 64'd0, "reset/res");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(4'b0000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, 0, "mul");
    do_op(4'b0011, M1, M1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0, "mulhu");
    do_op(4'b0001, MIN, MIN, 64'h4000_0000_0000_0000, 66, 0, "mulh");
    do_op(4'b0010, M1, M1, M1, 66, 0, "mulhsu");
    do_op(4'b0100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0, "div");
    do_op(4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, M1, 66, 0, "rem");
    do_op(4'b0101, 64'd7, 64'd2, 64'd3, 66, 10, "divu_hold");
    do_op(4'b0111, 64'd7, 64'd2, 64'd1, 66, 0, "remu");
    do_op(4'b0101, 64'd5, 64'd0, M1, 1, 0, "divu_z");
    do_op(4'b0110, 64'd5, 64'd0, 64'd5, 1, 0, "rem_z");
    do_op(4'b0100, MIN, M1, MIN, 1, 0, "div_ovf");
    do_op(4'b0110, MIN, M1, 64'd0, 1, 0, "rem_ovf");

    for (int k = 0; k < 14; k++) begin
      logic [3:0]  op;
      logic [63:0] a, b;
      op = 4'($urandom_range(0, 7));
      a  = {$urandom, $urandom} >> $urandom_range(0, 63);
      b  = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) a = -a;
      if ($urandom_range(0, 1) == 1) b = -b;
      if ($urandom_range(0, 5) == 0) b = 64'd0;
      do_op(op, a, b, ref_res(op, a, b), lat_exp(op, a, b), 0, "rand");
    end

`ifdef MDU_WORD_OP_EN
    do_op(4'b1100, 64'h1_8000_0000, M1, 64'hFFFF_FFFF_8000_0000, 1, 0, "divw_ovf");
    do_op(4'b1000, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0, "mulw");
`else
    do_op(4'b1000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, 0, "op3_mul");
    do_op(4'b1100, 64'h1_8000_0000, M1, 64'hFFFF_FFFE_8000_0000, 66, 0, "op3_div");
`endif

    // flush in BUSY cycle 20 with a competing request present
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'b0000; in_a = 64'd123; in_b = 64'd456;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk(64'(busy), 64'd1, "flush/pre");
    flush = 1'b1; in_valid = 1'b1; in_op = 4'b0101; in_a = 64'd9; in_b = 64'd0;
    @(posedge clk); #1;
    chk(64'({out_valid, busy, in_ready}), 64'b001, "flush/idle");
    @(posedge clk); #1;
    chk(64'(busy), 64'd0, "flush/noacc");
    flush = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(64'({out_valid, busy}), 64'b00, "flush/quiet");

    // async reset mid-BUSY; out_result currently holds the last nonzero result
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'b0101; in_a = 64'd1000; in_b = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(64'({out_valid, busy, in_ready}), 64'b001, "rstmid/ctl");
    chk(out_result, 64'd0, "rstmid/res");
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'b0101, 64'd1000, 64'd7, 64'd142, 66, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
